mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly after the execute stage. It registers the 155-bit execute-to-memory bus and performs word loads and stores to data memory over a req/gnt/rvalid handshake. It stalls the upstream pipeline while an access is outstanding and presents a 154-bit bus to writeback plus a forwarding bus to decode. It also detects misaligned accesses and bus timeouts.

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/mem_access_fsm.sv | 74 +++++++
 rtl/mem_stage.sv | 110 +++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: write-back select codes, stage bus widths,
// bus layouts and the memory-access FSM state encoding.
package riscv_pkg;

  localparam int EXE_MEM_W = 155;
  localparam int MEM_WB_W  = 154;
  localparam int MEM_ID_W  = 39;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC  = 3'd2;
  localparam logic [2:0] WB_CSR = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  // Execute-to-memory bus, MSB first. wb_data carries the store data.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  wb_sel;
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] op1_data;
  } exe_mem_t;

  // Memory-to-writeback bus, MSB first.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [2:0]  wb_sel;
    logic [31:0] pc;
    logic [3:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] op1_data;
    logic        mem_exc;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake sequencer with access timeout.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   ST_IDLE | no access outstanding, stage accepts a new op
//   ST_REQ  | dmem_req driven, waiting for dmem_gnt
//   ST_WAIT | load granted, waiting for dmem_rvalid
//
// The counter holds (cycles spent in REQ+WAIT) - 1, so the abort fires in the
// DMEM_TIMEOUT-th busy cycle. A grant or rvalid in that cycle takes priority.
module mem_access_fsm
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_is_store,
  input  logic i_gnt,
  input  logic i_rvalid,
  output logic o_busy,
  output logic o_req,
  output logic o_latch,
  output logic o_abort
);

  localparam logic [7:0] TMO_LAST = 8'(DMEM_TIMEOUT - 1);

  mem_state_e r_state;
  mem_state_e w_next;
  logic [7:0] r_cnt;
  logic       w_tmo;

  // ">=" so a grant landing in the last allowed cycle still times out in WAIT
  assign w_tmo = (r_cnt >= TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_REQ;
      ST_REQ: begin
        if (i_gnt)      w_next = i_is_store ? ST_IDLE : ST_WAIT;
        else if (w_tmo) w_next = ST_IDLE;
      end
      ST_WAIT: if (i_rvalid || w_tmo) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_busy  = (r_state != ST_IDLE);
    o_req   = (r_state == ST_REQ);
    o_latch = (r_state == ST_WAIT) && i_rvalid;
    o_abort = ((r_state == ST_REQ)  && !i_gnt    && w_tmo) ||
              ((r_state == ST_WAIT) && !i_rvalid && w_tmo);
  end

  // Busy-cycle counter, cleared whenever idle so it restarts on entry to REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= 8'd0;
    else if (r_state == ST_IDLE) r_cnt <= 8'd0;
    else                         r_cnt <= r_cnt + 8'd1;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, runs word
// loads/stores over req/gnt/rvalid, stalls upstream while busy, and flags
// misaligned accesses and bus timeouts.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EXE_MEM_W-1:0] exe_mem_bus_in,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_gnt,
  input  logic                 dmem_rvalid,
  input  logic [31:0]          dmem_rdata,
  output logic [MEM_WB_W-1:0]  mem_wb_bus_out,
  output logic [MEM_ID_W-1:0]  mem_id_data_bus,
  output logic                 mem_stall,
  output logic                 mem_err
);

  exe_mem_t    w_in;
  exe_mem_t    r_bus;
  mem_wb_t     w_wb;
  logic [31:0] r_ld;
  logic [31:0] w_fwd;
  logic        r_vld;
  logic        r_to_exc;
  logic        r_err;
  logic        w_stall, w_start, w_latch, w_abort;
  logic        w_in_mem, w_in_aligned, w_mis, w_exc;

  assign w_in         = exe_mem_bus_in;
  assign w_in_mem     = w_in.mem_we | w_in.mem_re;
  assign w_in_aligned = (w_in.alu_result[1:0] == 2'b00);
  assign w_start      = w_in_mem & w_in_aligned;

  mem_access_fsm #(.DMEM_TIMEOUT(DMEM_TIMEOUT)) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_is_store (r_bus.mem_we),
    .i_gnt      (dmem_gnt),
    .i_rvalid   (dmem_rvalid),
    .o_busy     (w_stall),
    .o_req      (dmem_req),
    .o_latch    (w_latch),
    .o_abort    (w_abort)
  );

  // Stage register: capture whenever not stalled; r_vld marks a real capture since reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus <= '0;
      r_vld <= 1'b0;
    end else if (!w_stall) begin
      r_bus <= w_in;
      r_vld <= 1'b1;
    end
  end

  // Load data holding register, written only by an rvalid accepted in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ld <= 32'd0;
    else if (w_latch) r_ld <= dmem_rdata;
  end

  // Timeout exception flag lives until the next capture; error pulse on abort or misaligned capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_exc <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_abort)       r_to_exc <= 1'b1;
      else if (!w_stall) r_to_exc <= 1'b0;
      r_err <= w_abort | (~w_stall & w_in_mem & ~w_in_aligned);
    end
  end

  assign w_mis = (r_bus.mem_we | r_bus.mem_re) & (r_bus.alu_result[1:0] != 2'b00);
  assign w_exc = w_mis | r_to_exc;

  // Write-back bus pack; a faulted op must not write its destination
  always_comb begin
    w_wb.alu_result = r_bus.alu_result;
    w_wb.load_data  = r_ld;
    w_wb.rd         = r_bus.rd;
    w_wb.rd_wen     = r_bus.rd_wen & ~w_exc;
    w_wb.wb_sel     = r_bus.wb_sel;
    w_wb.pc         = r_bus.pc;
    w_wb.csr_cmd    = r_bus.csr_cmd;
    w_wb.csr_addr   = r_bus.csr_addr;
    w_wb.op1_data   = r_bus.op1_data;
    w_wb.mem_exc    = w_exc;
  end

  assign w_fwd = (r_bus.wb_sel == WB_MEM) ? r_ld : r_bus.alu_result;

  assign mem_wb_bus_out  = w_stall ? '0 : w_wb;
  assign mem_id_data_bus = {r_bus.rd, r_bus.rd_wen, r_vld & ~w_stall, w_fwd};
  assign mem_stall       = w_stall;
  assign mem_err         = r_err;
  assign dmem_we         = r_bus.mem_we;
  assign dmem_addr       = r_bus.alu_result;
  assign dmem_wdata      = r_bus.wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps followed by random ops,
// each outcome predicted from the access rules (latencies, timeout budget).
module tb_mem_stage;
  import riscv_pkg::*;

  localparam int T = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [EXE_MEM_W-1:0] exe_mem_bus_in;
  logic                 dmem_req, dmem_we;
  logic [31:0]          dmem_addr, dmem_wdata;
  logic                 dmem_gnt, dmem_rvalid;
  logic [31:0]          dmem_rdata;
  logic [MEM_WB_W-1:0]  mem_wb_bus_out;
  logic [MEM_ID_W-1:0]  mem_id_data_bus;
  logic                 mem_stall, mem_err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0]         ld_r;
  logic [MEM_WB_W-1:0] exp_wb;
  logic [MEM_ID_W-1:0] exp_id;
  logic                exp_err;
  logic                late_rv;

  mem_stage #(.DMEM_TIMEOUT(T)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .exe_mem_bus_in  (exe_mem_bus_in),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .mem_wb_bus_out  (mem_wb_bus_out),
    .mem_id_data_bus (mem_id_data_bus),
    .mem_stall       (mem_stall),
    .mem_err         (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exe_mem_t mk_op(input logic [31:0] alu, input logic we, input logic re,
                                     input logic [2:0] sel, input logic [31:0] wdata);
    exe_mem_t o;
    o.alu_result = alu;
    o.rd         = 5'($urandom_range(0, 31));
    o.rd_wen     = 1'b1;
    o.mem_we     = we;
    o.mem_re     = re;
    o.wb_sel     = sel;
    o.pc         = $urandom();
    o.wb_data    = wdata;
    o.csr_cmd    = 4'($urandom_range(0, 15));
    o.csr_addr   = 12'($urandom_range(0, 4095));
    o.op1_data   = $urandom();
    return o;
  endfunction

  // Called at a negedge where the stage is expected idle with the previous op on its outputs
  task automatic check_idle();
    chk("idle_stall", 160'(mem_stall), 160'(1'b0));
    chk("idle_req",   160'(dmem_req),  160'(1'b0));
    chk("wb_bus",     160'(mem_wb_bus_out), 160'(exp_wb));
    chk("id_bus",     160'(mem_id_data_bus), 160'(exp_id));
    chk("mem_err",    160'(mem_err),   160'(exp_err));
  endtask

  // g: busy cycle (1-based) in which gnt is offered; d: cycles from gnt to rvalid
  task automatic do_op(input exe_mem_t op, input int g, input int d, input logic [31:0] rdata);
    logic memop, aligned, is_load, exc, done_ld;
    logic [159:0] junk;
    int s, reqend;
    check_idle();
    exe_mem_bus_in = op;
    dmem_gnt       = 1'b0;
    dmem_rvalid    = late_rv;
    dmem_rdata     = $urandom();
    memop   = op.mem_we | op.mem_re;
    aligned = (op.alu_result[1:0] == 2'b00);
    is_load = memop && aligned && !op.mem_we;
    exc     = memop && !aligned;
    done_ld = 1'b0;
    s = 0;
    reqend = 0;
    if (memop && aligned) begin
      if (op.mem_we) begin
        if (g <= T) s = g;
        else begin s = T; exc = 1'b1; end
        reqend = s;
      end else if (g > T) begin
        s = T; reqend = T; exc = 1'b1;
      end else begin
        reqend = g;
        if (d == 1 || g + d <= T) begin s = g + d; done_ld = 1'b1; end
        else begin s = (T > g + 1) ? T : g + 1; exc = 1'b1; end
      end
    end
    for (int k = 1; k <= s; k++) begin
      @(posedge clk);
      @(negedge clk);
      junk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      exe_mem_bus_in = junk[EXE_MEM_W-1:0];
      dmem_gnt    = (k == g);
      dmem_rvalid = done_ld && (k == g + d);
      dmem_rdata  = dmem_rvalid ? rdata : $urandom();
      chk("busy_stall", 160'(mem_stall), 160'(1'b1));
      chk("busy_req",   160'(dmem_req),  160'(k <= reqend));
      if (k <= reqend)
        chk("dmem_ctl", 160'({dmem_we, dmem_addr, dmem_wdata}),
            160'({op.mem_we, op.alu_result, op.wb_data}));
      chk("bubble",     160'(mem_wb_bus_out), 160'(0));
      chk("fwd_valid0", 160'(mem_id_data_bus[32]), 160'(1'b0));
      chk("busy_err",   160'(mem_err), 160'(1'b0));
    end
    @(posedge clk);
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    if (done_ld) ld_r = rdata;
    exp_wb  = {op.alu_result, ld_r, op.rd, op.rd_wen & ~exc, op.wb_sel, op.pc,
               op.csr_cmd, op.csr_addr, op.op1_data, exc};
    exp_id  = {op.rd, op.rd_wen, 1'b1, (op.wb_sel == WB_MEM) ? ld_r : op.alu_result};
    exp_err = exc;
    late_rv = is_load && exc;
  endtask

  initial begin
    exe_mem_t op;
    logic we, re;
    int kind;
    rst_n          = 1'b0;
    exe_mem_bus_in = '0;
    dmem_gnt       = 1'b0;
    dmem_rvalid    = 1'b0;
    dmem_rdata     = '0;
    ld_r    = '0;
    exp_wb  = '0;
    exp_id  = '0;
    exp_err = 1'b0;
    late_rv = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 160'({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall, mem_err}), 160'(0));
    chk("rst_wb", 160'(mem_wb_bus_out), 160'(0));
    chk("rst_id", 160'(mem_id_data_bus), 160'(0));
    rst_n = 1'b1;

    // Directed steps
    do_op(mk_op(32'h10, 1'b0, 1'b0, WB_ALU, 32'h0), 1, 1, 32'h0);
    do_op(mk_op(32'h100, 1'b1, 1'b0, WB_ALU, 32'hDEADBEEF), 1, 1, 32'h0);
    do_op(mk_op(32'h200, 1'b0, 1'b1, WB_MEM, 32'h0), 2, 3, 32'h12345678);
    do_op(mk_op(32'h202, 1'b0, 1'b1, WB_MEM, 32'h0), 1, 1, 32'h0);
    do_op(mk_op(32'h204, 1'b0, 1'b1, WB_MEM, 32'h0), 99, 1, 32'hCAFEF00D);
    do_op(mk_op(32'h20, 1'b0, 1'b0, WB_MEM, 32'h0), 1, 1, 32'h0);

    // Random ops
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      we = (kind == 2) || (kind == 3);
      re = (kind == 1) || (kind == 3);
      op = mk_op($urandom(), we, re, 3'($urandom_range(0, 3)), $urandom());
      op.rd_wen = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) != 0) op.alu_result[1:0] = 2'b00;
      do_op(op, $urandom_range(1, 6), $urandom_range(1, 4), $urandom());
    end

    // Reset while a load is waiting for rvalid
    check_idle();
    exe_mem_bus_in = mk_op(32'h300, 1'b0, 1'b1, WB_MEM, 32'h0);
    dmem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dmem_gnt = 1'b1;
    chk("rst_seq_req", 160'(dmem_req), 160'(1'b1));
    @(posedge clk);
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rst_seq_wait", 160'({mem_stall, dmem_req}), 160'(2'b10));
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 160'(dmem_req), 160'(1'b0));
    chk("midrst_outs", 160'({mem_stall, mem_err}), 160'(0));
    chk("midrst_wb", 160'(mem_wb_bus_out), 160'(0));
    chk("midrst_id", 160'(mem_id_data_bus), 160'(0));
    @(negedge clk);
    exe_mem_bus_in = '0;
    rst_n   = 1'b1;
    ld_r    = '0;
    exp_wb  = '0;
    exp_id  = '0;
    exp_err = 1'b0;
    late_rv = 1'b0;

    do_op(mk_op(32'h400, 1'b0, 1'b1, WB_MEM, 32'h0), 1, 1, 32'hA5A5_0001);
    do_op(mk_op(32'h404, 1'b1, 1'b0, WB_ALU, 32'h5A5A_0002), 3, 1, 32'h0);
    do_op(mk_op(32'h44, 1'b0, 1'b0, WB_MEM, 32'h0), 1, 1, 32'h0);
    check_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
